// File: rtl/pwm_peripheral.sv
// pwm_peripheral
//   Drives 16 output pins. Each pin is forced low, held high, or follows one
//   shared PWM waveform. The enable and duty registers that control it are
//   written over SPI by spi_peripheral. A prescaler divides clk by CLK_DIV
//   into count ticks. An 8-bit period counter advances on each tick. The
//   requested duty is copied into a shadow register only when the period
//   wraps, so a high pulse is never cut short or stretched mid-period.
//
// Parameters
//   CLK_DIV   clk cycles per PWM count (>= 1)
//   CNT_W     prescaler width, 2**CNT_W >= CLK_DIV
//
// Ports
//   clk               in   1   system clock
//   rst_n             in   1   asynchronous active-low reset
//   en_reg_out_7_0    in   8   output enable, pins 7..0
//   en_reg_out_15_8   in   8   output enable, pins 15..8
//   en_reg_pwm_7_0    in   8   PWM select, pins 7..0
//   en_reg_pwm_15_8   in   8   PWM select, pins 15..8
//   pwm_duty_cycle    in   8   requested duty, N/256 (0xFF = always high)
//   out               out  16  registered pin drive
//   period_start      out  1   one-clk pulse in the cycle pwm_cnt becomes 0
module pwm_peripheral #(
  parameter int CLK_DIV = 13,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] presc;
  logic             tick;
  logic [7:0]       pwm_cnt;
  logic [7:0]       duty_act;
  logic             wrap;
  logic             pwm_sig;
  logic [15:0]      en_o;
  logic [15:0]      en_p;
  logic [15:0]      next_out;

  assign en_o = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_p = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // When CLK_DIV is 1, PRESC_LAST is 0. tick is then high on every clk and
  // pwm_cnt advances once per clk.
  assign tick = (presc == PRESC_LAST);

  // The last count of the period. The next tick wraps pwm_cnt to 0.
  assign wrap = tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= 8'd0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // The shadow duty changes only at the wrap. Writes made mid-period wait
  // for the next boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_act <= 8'd0;
    end else if (wrap) begin
      duty_act <= pwm_duty_cycle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
    end
  end

  // A plain compare would drop low for the last count (255 < 255 is false).
  // 0xFF is therefore treated as a true 100 % duty.
  always_comb begin
    pwm_sig = 1'b0;
    if (duty_act == 8'hFF) begin
      pwm_sig = 1'b1;
    end else begin
      pwm_sig = (pwm_cnt < duty_act);
    end
  end

  // The output enable has priority. A pin that is enabled but not PWM-selected
  // is held high.
  assign next_out = en_o & (~en_p | {16{pwm_sig}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= 16'h0000;
    end else begin
      out <= next_out;
    end
  end

endmodule
